// File: rtl/maxpool_stage.sv
// 2x2 stride-2 max-pool stage: reads the layer-0 map from bank 001,
// writes the half-size layer-1 map to bank 011.
module maxpool_stage #(
  parameter int DW    = 20,
  parameter int IMG_W = 64,
  parameter int AW    = 12
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  output logic          busy,
  output logic          done,
  output logic          crd,
  output logic [AW-1:0] caddr_rd,
  input  logic [DW-1:0] cdata_rd,
  output logic          cwr,
  output logic [AW-1:0] caddr_wr,
  output logic [DW-1:0] cdata_wr,
  output logic [2:0]    csel
);

  localparam int LW = $clog2(IMG_W);
  localparam int OB = LW - 1;

  typedef enum logic [2:0] {
    IDLE, RD0, RD1, RD2, RD3, WR, FIN
  } state_t;

  state_t        state;
  logic [OB-1:0] row;
  logic [OB-1:0] col;
  logic [OB-1:0] row_n;
  logic [OB-1:0] col_n;
  logic [DW-1:0] max_q;
  logic [DW-1:0] pick;
  logic          last;

  function automatic logic [AW-1:0] win(
    input logic [OB-1:0] r,
    input logic [OB-1:0] c,
    input logic [1:0]    i
  );
    logic [AW-1:0] a;
    a = (AW'(r) << (LW + 1)) + (AW'(c) << 1);
    if (i[1]) a = a + AW'(IMG_W);
    if (i[0]) a = a + AW'(1);
    return a;
  endfunction

  // Strict greater-than keeps the running max on ties.
  always_comb begin
    pick  = ($signed(cdata_rd) > $signed(max_q)) ? cdata_rd : max_q;
    last  = &{row, col};
    col_n = col + OB'(1);
    row_n = (&col) ? row + OB'(1) : row;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      row      <= '0;
      col      <= '0;
      max_q    <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      crd      <= 1'b0;
      cwr      <= 1'b0;
      caddr_rd <= '0;
      caddr_wr <= '0;
      cdata_wr <= '0;
      csel     <= 3'b000;
    end else begin
      unique case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            state    <= RD0;
            row      <= '0;
            col      <= '0;
            busy     <= 1'b1;
            crd      <= 1'b1;
            csel     <= 3'b001;
            caddr_rd <= win('0, '0, 2'd0);
          end
        end
        RD0: begin
          max_q    <= cdata_rd;
          state    <= RD1;
          caddr_rd <= win(row, col, 2'd1);
        end
        RD1: begin
          max_q    <= pick;
          state    <= RD2;
          caddr_rd <= win(row, col, 2'd2);
        end
        RD2: begin
          max_q    <= pick;
          state    <= RD3;
          caddr_rd <= win(row, col, 2'd3);
        end
        RD3: begin
          max_q    <= pick;
          cdata_wr <= pick;
          caddr_wr <= AW'({row, col});
          crd      <= 1'b0;
          cwr      <= 1'b1;
          csel     <= 3'b011;
          state    <= WR;
        end
        WR: begin
          cwr <= 1'b0;
          if (last) begin
            state <= FIN;
            busy  <= 1'b0;
            done  <= 1'b1;
            csel  <= 3'b000;
          end else begin
            state    <= RD0;
            row      <= row_n;
            col      <= col_n;
            crd      <= 1'b1;
            csel     <= 3'b001;
            caddr_rd <= win(row_n, col_n, 2'd0);
          end
        end
        FIN: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
